// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle MIPS datapath.
// Holds the PC source select codes, the exception cause codes and the
// default reset/exception vectors.
package cpu_pkg;

  // Next-PC source select.
  localparam logic [2:0] PCSRC_ALU  = 3'b000; // PC+4 from the ALU
  localparam logic [2:0] PCSRC_C    = 3'b001; // registered branch target
  localparam logic [2:0] PCSRC_JUMP = 3'b010; // j/jal pseudo-direct target
  localparam logic [2:0] PCSRC_RS   = 3'b011; // jr
  localparam logic [2:0] PCSRC_RAS  = 3'b100; // jr $ra predicted by RAS
  localparam logic [2:0] PCSRC_EPC  = 3'b101; // eret

  // Exception cause codes.
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0180;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack.
// Ports: push/pop strobes, din (value pushed), top (current top entry),
// count (valid entries), empty, sticky ovf (push while full) and unf
// (pop while empty). A push while full overwrites the oldest entry.
// A simultaneous push+pop on a non-empty stack replaces the top in place.
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 32,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  top,
  output logic [PW:0]   count,
  output logic          empty,
  output logic          ovf,
  output logic          unf
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wp_q, wp_d, tp;
  logic [PW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  logic          full, wr_en;
  logic [PW-1:0] wr_idx;

  assign tp    = wp_q - PW'(1);
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (PW+1)'(DEPTH));
  assign top   = mem_q[tp];
  assign count = cnt_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

  always_comb begin
    wp_d   = wp_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    wr_en  = push;
    wr_idx = wp_q;
    if (push && pop && !empty) begin
      // Pop consumes the old top, push lands in the same slot.
      wr_idx = tp;
    end else begin
      if (pop) begin
        if (empty) unf_d = 1'b1;
        else begin
          wp_d  = tp;
          cnt_d = cnt_q - (PW+1)'(1);
        end
      end
      if (push) begin
        wp_d = wp_q + PW'(1);
        if (full) ovf_d = 1'b1;
        else      cnt_d = cnt_q + (PW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Entry contents need no reset; only the pointer and count do.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= din;
  end

endmodule

// File: rtl/pc_ctrl_unit.sv
// Program-counter unit for the multicycle MIPS datapath.
// Holds PC, EPC, cause, EXL and a return-address stack. The next PC is
// selected from pcsource and committed on a qualified write strobe
// (pc_write, or pc_write_cond with branch_taken). Misaligned or reserved
// targets and external requests vector to EXC_VEC.
// Ports: clk/rst, write strobes, branch_taken, pcsource, candidate targets
// (alu_out, c_data, ir_data, rs_data), ras_push, exc_req/exc_code;
// outputs pc, epc, cause, exl, exc_taken, ras_count, ras_ovf, ras_unf.
module pc_ctrl_unit import cpu_pkg::*; #(
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_VEC = PC_W'(DEF_RESET_VEC),
  parameter logic [PC_W-1:0] EXC_VEC   = PC_W'(DEF_EXC_VEC),
  parameter int              RAS_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pc_write,
  input  logic                       pc_write_cond,
  input  logic                       branch_taken,
  input  logic [2:0]                 pcsource,
  input  logic [PC_W-1:0]            alu_out,
  input  logic [PC_W-1:0]            c_data,
  input  logic [31:0]                ir_data,
  input  logic [PC_W-1:0]            rs_data,
  input  logic                       ras_push,
  input  logic                       exc_req,
  input  logic [4:0]                 exc_code,
  output logic [PC_W-1:0]            pc,
  output logic [PC_W-1:0]            epc,
  output logic [4:0]                 cause,
  output logic                       exl,
  output logic                       exc_taken,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_ovf,
  output logic                       ras_unf
);

  logic [PC_W-1:0] pc_q, pc_d, epc_q, epc_d, npc, ras_top;
  logic [4:0]      cause_q, cause_d;
  logic            exl_q, exl_d, tk_q, tk_d;
  logic            we, rsv, addr_err, exc, ras_empty, do_push, do_pop;
  logic            unused_ir;

  assign unused_ir = ^ir_data[31:26];

  ras_stack #(.DEPTH(RAS_DEPTH), .W(PC_W)) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (do_push),
    .pop   (do_pop),
    .din   (pc_q),
    .top   (ras_top),
    .count (ras_count),
    .empty (ras_empty),
    .ovf   (ras_ovf),
    .unf   (ras_unf)
  );

  always_comb begin
    we  = pc_write | (pc_write_cond & branch_taken);
    npc = pc_q;
    rsv = 1'b0;
    case (pcsource)
      PCSRC_ALU:  npc = alu_out;
      PCSRC_C:    npc = c_data;
      PCSRC_JUMP: npc = {pc_q[PC_W-1:28], ir_data[25:0], 2'b00};
      PCSRC_RS:   npc = rs_data;
      PCSRC_RAS:  npc = ras_empty ? rs_data : ras_top; // underflow falls back to jr
      PCSRC_EPC:  npc = epc_q;
      default:    rsv = 1'b1;                         // reserved select traps
    endcase
    addr_err = we & (rsv | (npc[1:0] != 2'b00));
    exc      = exc_req | addr_err;
    do_push  = ras_push & ~exc;
    do_pop   = we & (pcsource == PCSRC_RAS) & ~exc;

    pc_d    = pc_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    exl_d   = exl_q;
    tk_d    = exc;
    if (exc) begin
      pc_d    = EXC_VEC;
      cause_d = exc_req ? exc_code : EXC_ADEL;
      // Nested exceptions keep the original return address.
      if (!exl_q) begin
        epc_d = pc_q;
        exl_d = 1'b1;
      end
    end else if (we) begin
      pc_d = npc;
      if (pcsource == PCSRC_EPC) exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_VEC;
      epc_q   <= '0;
      cause_q <= '0;
      exl_q   <= 1'b0;
      tk_q    <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      exl_q   <= exl_d;
      tk_q    <= tk_d;
    end
  end

  assign pc        = pc_q;
  assign epc       = epc_q;
  assign cause     = cause_q;
  assign exl       = exl_q;
  assign exc_taken = tk_q;

endmodule

// File: tb/tb_pc_ctrl_unit.sv
module tb_pc_ctrl_unit;

  localparam logic [31:0] EXC = 32'h0000_0180;

  logic        clk = 1'b0;
  logic        rst, pc_write, pc_write_cond, branch_taken, ras_push, exc_req;
  logic [2:0]  pcsource;
  logic [31:0] alu_out, c_data, ir_data, rs_data;
  logic [4:0]  exc_code;
  logic [31:0] pc, epc;
  logic [4:0]  cause;
  logic        exl, exc_taken, ras_ovf, ras_unf;
  logic [2:0]  ras_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_ctrl_unit dut (
    .clk(clk), .rst(rst), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .branch_taken(branch_taken), .pcsource(pcsource), .alu_out(alu_out),
    .c_data(c_data), .ir_data(ir_data), .rs_data(rs_data), .ras_push(ras_push),
    .exc_req(exc_req), .exc_code(exc_code), .pc(pc), .epc(epc), .cause(cause),
    .exl(exl), .exc_taken(exc_taken), .ras_count(ras_count), .ras_ovf(ras_ovf),
    .ras_unf(ras_unf)
  );

  // ---------------- behavioural reference model ----------------
  logic [31:0] m_pc, m_epc;
  logic [4:0]  m_cause;
  bit          m_exl, m_tk, m_ovf, m_unf;
  logic [31:0] m_ras[$];

  task automatic model_reset();
    m_pc = 0; m_epc = 0; m_cause = 0; m_exl = 0; m_tk = 0;
    m_ovf = 0; m_unf = 0; m_ras.delete();
  endtask

  task automatic model_step();
    bit we, bad, ex, pop, push;
    logic [31:0] tgt;
    we  = pc_write || (pc_write_cond && branch_taken);
    bad = 0;
    case (pcsource)
      3'd0: tgt = alu_out;
      3'd1: tgt = c_data;
      3'd2: tgt = (m_pc & 32'hF000_0000) | ((ir_data & 32'h03FF_FFFF) << 2);
      3'd3: tgt = rs_data;
      3'd4: tgt = (m_ras.size() == 0) ? rs_data : m_ras[m_ras.size()-1];
      3'd5: tgt = m_epc;
      default: begin tgt = m_pc; bad = 1; end
    endcase
    ex   = exc_req || (we && (bad || (tgt % 4 != 0)));
    m_tk = ex;
    if (ex) begin
      m_cause = exc_req ? exc_code : 5'd4;
      if (!m_exl) begin m_epc = m_pc; m_exl = 1; end
      m_pc = EXC;
    end else begin
      pop  = we && (pcsource == 3'd4);
      push = ras_push;
      if (pop && push && m_ras.size() > 0) begin
        m_ras[m_ras.size()-1] = m_pc;
      end else begin
        if (pop) begin
          if (m_ras.size() == 0) m_unf = 1;
          else void'(m_ras.pop_back());
        end
        if (push) begin
          m_ras.push_back(m_pc);
          if (m_ras.size() > 4) begin void'(m_ras.pop_front()); m_ovf = 1; end
        end
      end
      if (we) begin
        if (pcsource == 3'd5) m_exl = 0;
        m_pc = tgt;
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic compare_model();
    check("m_pc", pc, m_pc);
    check("m_epc", epc, m_epc);
    check("m_cause", 32'(cause), 32'(m_cause));
    check("m_exl", 32'(exl), 32'(m_exl));
    check("m_exc_taken", 32'(exc_taken), 32'(m_tk));
    check("m_ras_count", 32'(ras_count), 32'(m_ras.size()));
    check("m_ras_ovf", 32'(ras_ovf), 32'(m_ovf));
    check("m_ras_unf", 32'(ras_unf), 32'(m_unf));
  endtask

  task automatic idle();
    rst = 0; pc_write = 0; pc_write_cond = 0; branch_taken = 0; pcsource = 0;
    alu_out = 0; c_data = 0; ir_data = 0; rs_data = 0; ras_push = 0;
    exc_req = 0; exc_code = 0;
  endtask

  // Apply the currently driven inputs for one clock edge.
  task automatic step();
    if (rst) model_reset(); else model_step();
    @(posedge clk); #1;
    compare_model();
  endtask

  task automatic wr(input logic [2:0] src, input logic [31:0] val, input bit push);
    idle(); pc_write = 1; pcsource = src; ras_push = push;
    alu_out = val; rs_data = val;
    step();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic pw, pwc, bt; logic [2:0] src;
    logic [31:0] alu, cd, ir, rs;
    logic exc; logic [4:0] code;
    logic [31:0] e_pc, e_epc; logic e_exl; logic [4:0] e_cause; logic e_tk;
  } vec_t;

  function automatic vec_t mk(input int pw, pwc, bt, src, input logic [31:0] alu, cd, ir, rs,
                              input int exc, code, input logic [31:0] e_pc, e_epc,
                              input int e_exl, e_cause, e_tk);
    vec_t v;
    v.pw = pw[0]; v.pwc = pwc[0]; v.bt = bt[0]; v.src = 3'(src);
    v.alu = alu; v.cd = cd; v.ir = ir; v.rs = rs;
    v.exc = exc[0]; v.code = 5'(code);
    v.e_pc = e_pc; v.e_epc = e_epc; v.e_exl = e_exl[0]; v.e_cause = 5'(e_cause); v.e_tk = e_tk[0];
    return v;
  endfunction

  vec_t tbl[18];

  initial begin
    //                 pw pwc bt src alu           cd            ir            rs        exc code pc            epc     exl cause tk
    tbl[0]  = mk(1, 0, 0, 0, 32'h4,        0,            0,            0,          0, 0, 32'h4,        0,          0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 1, 0,            32'h40,       0,            0,          0, 0, 32'h4,        0,          0, 0, 0);
    tbl[2]  = mk(0, 1, 1, 1, 0,            32'h40,       0,            0,          0, 0, 32'h40,       0,          0, 0, 0);
    tbl[3]  = mk(1, 0, 0, 1, 0,            32'h1000_0000,0,            0,          0, 0, 32'h1000_0000,0,          0, 0, 0);
    tbl[4]  = mk(1, 0, 0, 2, 0,            0,            32'h0800_0010,0,          0, 0, 32'h1000_0040,0,          0, 0, 0);
    tbl[5]  = mk(1, 0, 0, 0, 32'h200,      0,            0,            0,          0, 0, 32'h200,      0,          0, 0, 0);
    tbl[6]  = mk(1, 0, 0, 3, 0,            0,            0,            32'h102,    0, 0, EXC,          32'h200,    1, 4, 1);
    tbl[7]  = mk(0, 0, 0, 0, 0,            0,            0,            0,          0, 0, EXC,          32'h200,    1, 4, 0);
    tbl[8]  = mk(1, 0, 0, 5, 0,            0,            0,            0,          0, 0, 32'h200,      32'h200,    0, 4, 0);
    tbl[9]  = mk(1, 0, 0, 0, 32'h300,      0,            0,            0,          0, 0, 32'h300,      32'h200,    0, 4, 0);
    tbl[10] = mk(0, 0, 0, 0, 0,            0,            0,            0,          1, 0, EXC,          32'h300,    1, 0, 1);
    tbl[11] = mk(1, 0, 0, 0, 32'h184,      0,            0,            0,          0, 0, 32'h184,      32'h300,    1, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 0,            0,            0,            0,          1, 8, EXC,          32'h300,    1, 8, 1);
    tbl[13] = mk(1, 0, 0, 5, 0,            0,            0,            0,          0, 0, 32'h300,      32'h300,    0, 8, 0);
    tbl[14] = mk(1, 0, 0, 0, 32'h500,      0,            0,            0,          1, 12,EXC,          32'h300,    1, 12,1);
    tbl[15] = mk(1, 0, 0, 5, 0,            0,            0,            0,          0, 0, 32'h300,      32'h300,    0, 12,0);
    tbl[16] = mk(1, 0, 0, 6, 0,            0,            0,            0,          0, 0, EXC,          32'h300,    1, 4, 1);
    tbl[17] = mk(1, 0, 0, 5, 0,            0,            0,            0,          0, 0, 32'h300,      32'h300,    0, 4, 0);
  end

  task automatic do_reset();
    idle(); rst = 1;
    step(); step();
    idle();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    idle();
    #1;
    do_reset();
    check("rst_pc", pc, 32'h0);
    check("rst_epc", epc, 32'h0);
    check("rst_cause", 32'(cause), 32'h0);
    check("rst_exl", 32'(exl), 32'h0);
    check("rst_exc_taken", 32'(exc_taken), 32'h0);
    check("rst_ras_count", 32'(ras_count), 32'h0);
    check("rst_ras_ovf", 32'(ras_ovf), 32'h0);
    check("rst_ras_unf", 32'(ras_unf), 32'h0);

    for (int i = 0; i < 18; i++) begin
      idle();
      pc_write = tbl[i].pw; pc_write_cond = tbl[i].pwc; branch_taken = tbl[i].bt;
      pcsource = tbl[i].src; alu_out = tbl[i].alu; c_data = tbl[i].cd;
      ir_data = tbl[i].ir; rs_data = tbl[i].rs; exc_req = tbl[i].exc; exc_code = tbl[i].code;
      step();
      check($sformatf("vec%0d_pc", i), pc, tbl[i].e_pc);
      check($sformatf("vec%0d_epc", i), epc, tbl[i].e_epc);
      check($sformatf("vec%0d_exl", i), 32'(exl), 32'(tbl[i].e_exl));
      check($sformatf("vec%0d_cause", i), 32'(cause), 32'(tbl[i].e_cause));
      check($sformatf("vec%0d_exc_taken", i), 32'(exc_taken), 32'(tbl[i].e_tk));
    end

    // RAS overflow: push pc=0x10..0x50 into a 4-deep stack.
    do_reset();
    wr(3'd0, 32'h10, 0);
    for (int k = 1; k <= 5; k++) wr(3'd0, 32'(16 * (k + 1)), 1);
    check("ras_full_count", 32'(ras_count), 32'd4);
    check("ras_full_ovf", 32'(ras_ovf), 32'd1);
    for (int k = 0; k < 4; k++) begin
      wr(3'd4, 32'h0, 0);
      check($sformatf("ras_pop%0d_pc", k), pc, 32'(32'h50 - 16 * k));
    end
    wr(3'd4, 32'h88, 0);
    check("ras_unf_pc", pc, 32'h88);
    check("ras_unf_flag", 32'(ras_unf), 32'd1);
    check("ras_unf_count", 32'(ras_count), 32'd0);
    check("ras_unf_exl", 32'(exl), 32'd0);

    // Simultaneous push+pop replaces the top in place.
    wr(3'd0, 32'h40, 0);
    wr(3'd0, 32'h60, 1);
    check("pp_pre_count", 32'(ras_count), 32'd1);
    wr(3'd4, 32'h0, 1);
    check("pp_pc", pc, 32'h40);
    check("pp_count", 32'(ras_count), 32'd1);
    wr(3'd4, 32'h0, 0);
    check("pp_next_pop", pc, 32'h60);
    check("pp_sticky_ovf", 32'(ras_ovf), 32'd1);

    // Randomized traffic against the reference model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      idle();
      rst           = ($urandom_range(0, 199) == 0);
      pc_write      = ($urandom_range(0, 99) < 50);
      pc_write_cond = ($urandom_range(0, 3) == 0);
      branch_taken  = ($urandom_range(0, 1) == 1);
      pcsource      = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(6, 7))
                                                   : 3'($urandom_range(0, 5));
      alu_out  = ($urandom & 32'h0000_FFFC) | 32'($urandom_range(0, 9) == 0);
      c_data   = ($urandom & 32'h0000_FFFC) | 32'($urandom_range(0, 9) == 0);
      rs_data  = ($urandom & 32'h0000_FFFC) | 32'($urandom_range(0, 9) == 0);
      ir_data  = $urandom;
      ras_push = ($urandom_range(0, 2) == 0);
      exc_req  = ($urandom_range(0, 15) == 0);
      exc_code = 5'($urandom_range(0, 31));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_ctrl_unit.md
Name: pc_ctrl_unit

Overview:
- Parametrised program-counter unit for the multicycle MIPS datapath.
- Holds PC, EPC, cause and an exception-level (EXL) bit, plus a RAS_DEPTH-entry return-address stack (RAS) for jal/jr $ra.
- Selects next PC from six sources and detects misaligned targets.
- Vectors to the exception handler on external or address-error exceptions.
- Driven by the multicycle controller; a qualified pc_write/pc_write_cond strobe replaces clocking the PC on a write edge.

Parameters:
- PC_W, 32, PC/data width; must be >= 32.
- RESET_VEC, 32'h0000_0000, PC value after reset.
- EXC_VEC, 32'h0000_0180, exception handler entry.
- RAS_DEPTH, 4, return-address stack entries; power of 2, >= 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- pc_write  in  1  unconditional PC update this cycle.
- pc_write_cond  in  1  PC update only if branch_taken.
- branch_taken  in  1  branch condition from the ALU.
- pcsource  in  3  000 alu_out, 001 c_data, 010 jump, 011 rs_data, 100 RAS pop, 101 EPC (eret); 110/111 reserved.
- alu_out  in  PC_W  combinational ALU result (PC+4).
- c_data  in  PC_W  registered ALU output (branch target).
- ir_data  in  32  current instruction.
- rs_data  in  PC_W  register-file rs value (jr).
- ras_push  in  1  push current pc (jal in execute).
- exc_req  in  1  external exception request.
- exc_code  in  5  cause code for exc_req.
- pc  out  PC_W  program counter.
- epc  out  PC_W  exception PC.
- cause  out  5  last exception code.
- exl  out  1  in-exception status.
- exc_taken  out  1  one-cycle pulse when vectoring.
- ras_count  out  $clog2(RAS_DEPTH)+1  valid entries.
- ras_ovf  out  1  sticky: push while full.
- ras_unf  out  1  sticky: pop while empty.

Behaviour:
- Reset values: pc=RESET_VEC, epc=0, cause=0, exl=0, exc_taken=0, ras_count=0, ras_ovf=0, ras_unf=0. Reset clears the RAS pointer; entry contents need no reset.
- we = pc_write | (pc_write_cond & branch_taken).
- Jump target = {pc[PC_W-1:28], ir_data[25:0], 2'b00}.
- npc mux is combinational on pcsource. For a reserved code, npc = pc and addr_err is forced.
- RAS pop target = top entry. When empty, npc = rs_data and ras_unf is set.
- addr_err = we & (npc[1:0] != 0).
- Per-cycle priority: rst > exc_req > addr_err > we > hold.
- Exception vectoring (exc_req, or addr_err; cause 5'd4 AdEL for addr_err):
  - pc <= EXC_VEC, exc_taken=1 for exactly that cycle, cause <= code.
  - If exl==0: epc <= pc and exl <= 1.
  - If exl==1 (nested): epc is held and cause is still updated.
  - No RAS push or pop occurs in a vectoring cycle.
- eret (we & pcsource==101, no exception): pc <= epc, exl <= 0.
- exc_req with pc_write in the same cycle: the exception wins and the write is discarded.
- RAS push (ras_push & no exception): stack[wp] <= pc, wp <= wp+1 (mod depth), count = min(count+1, RAS_DEPTH).
  - When full, the push overwrites the oldest entry (circular) and sets ras_ovf.
- RAS pop (we & pcsource==100 & no exception): wp <= wp-1, count <= count-1.
  - Empty: pointer and count unchanged, ras_unf set.
- Push and pop in the same cycle: the popped value is the old top. The new entry replaces it; wp and count are unchanged.
- Sticky flags clear only on rst.
- Latency: pc, epc, cause and RAS state update one cycle after the strobe. pc is never updated combinationally.

Decomposition:
- Shared package cpu_pkg holds:
  - PCSRC_ALU/_C/_JUMP/_RS/_RAS/_EPC constants.
  - EXC_ADEL=5'd4 and other cause codes.
  - Default EXC_VEC and RESET_VEC.
- One sub-module, ras_stack: circular LIFO with push/pop/top/count/ovf/unf, parametrised by depth and width.
- npc mux and exception control stay inline in pc_ctrl_unit.

Test Plan:
- Reset: rst=1 for 2 cycles, then release -> pc=0, epc=0, exl=0, ras_count=0; with pc_write=1, pcsource=000, alu_out=4 -> pc=4 next cycle.
- Branch and jump:
  - pc_write_cond=1, branch_taken=0, c_data=0x40 -> pc holds.
  - Same stimulus with branch_taken=1 -> pc=0x40.
  - pc=0x10000000, ir_data=0x08000010, pcsource=010 -> pc=0x10000040.
- Misaligned target: pcsource=011, rs_data=0x102, pc=0x200 -> pc=0x180, epc=0x200, cause=4, exl=1, exc_taken pulses once.
- Nested exception and eret:
  - exc_req (code 0) at pc=0x300 -> epc=0x300.
  - Second exc_req at pc=0x184 -> epc stays 0x300, pc=0x180.
  - pcsource=101 with pc_write -> pc=0x300, exl=0.
  - exc_req together with pc_write -> the exception wins.
- RAS (RAS_DEPTH=4):
  - Push at pc=0x10,0x20,0x30,0x40,0x50 -> ras_count=4, ras_ovf=1.
  - Four pops -> pc=0x50,0x40,0x30,0x20.
  - Fifth pop with rs_data=0x88 -> pc=0x88, ras_unf=1, ras_count=0.
- Simultaneous push+pop with top=0x40 at pc=0x60 -> pc=0x40, ras_count unchanged, next pop returns 0x60.
